sd_port_arbiter: RTL and testbench

- Shares the single SD-card block interface between the floppy track buffer (two image slots, int/ext drive) and the SCSI hard-disk controller (one image slot).
- Only one requester owns the SD port at a time, from strobe until the host drops busy. A floppy write-back can therefore never interleave with SCSI I/O.
- Sits between the requesters and the SD host (firmware/ARM side).
- Non-owners see busy held high, so they stall in their idle state.

---
 rtl/sd_arb_pkg.sv | 16 +
 rtl/sd_rr_grant.sv | 19 +
 rtl/sd_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sd_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared state, owner and slot encodings for the SD port arbiter
package sd_arb_pkg;
  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_RELEASE
  } state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_FD = 2'd1;
  localparam logic [1:0] OWN_HD = 2'd2;
  localparam int SLOT_FD0 = 0;
  localparam int SLOT_FD1 = 1;
  localparam int SLOT_HD = 2;
endpackage

// File: rtl/sd_rr_grant.sv
// sd_rr_grant: two-way round-robin grant, floppy wins the first tie after reset
module sd_rr_grant (
  input  logic clk,
  input  logic rst,
  input  logic req_fd,
  input  logic req_hd,
  input  logic upd,
  input  logic upd_hd,
  output logic gnt_fd,
  output logic gnt_hd
);
  logic last_hd_q, last_hd_d;
  assign gnt_fd = req_fd && (!req_hd || last_hd_q);
  assign gnt_hd = req_hd && (!req_fd || !last_hd_q);
  // remember who was served last, updated once per finished transfer
  always_comb last_hd_d = upd ? upd_hd : last_hd_q;
  // last_grant starts as scsi so the floppy wins the first tie
  always_ff @(posedge clk) last_hd_q <= rst ? 1'b1 : last_hd_d;
endmodule

// File: rtl/sd_port_arbiter.sv
// sd_port_arbiter: shares one SD host block port between floppy and SCSI requesters
import sd_arb_pkg::*;
module sd_port_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd4_000_000,
  parameter int NIMG = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     fd_lba,
  input  logic [1:0]      fd_rd,
  input  logic [1:0]      fd_wr,
  output logic            fd_busy,
  output logic            fd_data_en,
  input  logic [7:0]      fd_data_out,
  input  logic [31:0]     hd_lba,
  input  logic            hd_rd,
  input  logic            hd_wr,
  output logic            hd_busy,
  output logic            hd_data_en,
  input  logic [7:0]      hd_data_out,
  output logic [31:0]     sd_lba,
  output logic [NIMG-1:0] sd_rd,
  output logic [NIMG-1:0] sd_wr,
  input  logic            sd_busy,
  input  logic            sd_data_en,
  output logic [7:0]      sd_data_out,
  output logic [1:0]      owner,
  output logic            timeout_err
);
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [31:0] lba_q, lba_d;
  logic [NIMG-1:0] slot_q, slot_d;
  logic wr_q, wr_d;
  logic [23:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic fd_req, hd_req, gnt_fd, gnt_hd, grant, issue, own_busy, xfer;
  logic [1:0] fd_sel;
  logic [NIMG-1:0] fd_slot;
  assign fd_req = |fd_rd || |fd_wr;
  assign hd_req = hd_rd || hd_wr;
  assign fd_sel = |fd_rd ? fd_rd : fd_wr;
  assign fd_slot = fd_sel[0] ? NIMG'(1) << SLOT_FD0 : NIMG'(1) << SLOT_FD1;
  assign grant = state_q == ST_IDLE && !sd_busy && (gnt_fd || gnt_hd);
  sd_rr_grant u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_fd (fd_req),
    .req_hd (hd_req),
    .upd    (state_q == ST_RELEASE),
    .upd_hd (owner_q == OWN_HD),
    .gnt_fd (gnt_fd),
    .gnt_hd (gnt_hd)
  );
  // port ownership sequence: grant, wait for host busy, transfer, release
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lba_d = lba_q;
    slot_d = slot_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      ST_RST: state_d = ST_IDLE;
      ST_IDLE: if (grant) begin
        state_d = ST_ISSUE;
        owner_d = gnt_fd ? OWN_FD : OWN_HD;
        lba_d = gnt_fd ? {21'd0, fd_lba} : hd_lba;
        slot_d = gnt_fd ? fd_slot : NIMG'(1) << SLOT_HD;
        wr_d = gnt_fd ? !(|fd_rd) : !hd_rd;
        cnt_d = '0;
      end
      ST_ISSUE: if (sd_busy) state_d = ST_XFER;
        else if (cnt_q == TIMEOUT - 24'd1) begin
          state_d = ST_RELEASE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 24'd1;
      ST_XFER: if (!sd_busy) state_d = ST_RELEASE;
      ST_RELEASE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ST_RST;
    endcase
  end
  // state and latched request registers; reset abandons any host transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      owner_q <= OWN_NONE;
      lba_q <= '0;
      slot_q <= '0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lba_q <= lba_d;
      slot_q <= slot_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign issue = state_q == ST_ISSUE && !sd_busy;
  assign xfer = state_q == ST_XFER;
  assign own_busy = (state_q == ST_ISSUE || xfer) && sd_busy;
  assign sd_rd = issue && !wr_q ? slot_q : '0;
  assign sd_wr = issue && wr_q ? slot_q : '0;
  assign sd_lba = lba_q;
  assign fd_busy = state_q == ST_RST || (owner_q == OWN_FD ? own_busy : owner_q != OWN_NONE);
  assign hd_busy = state_q == ST_RST || (owner_q == OWN_HD ? own_busy : owner_q != OWN_NONE);
  assign fd_data_en = xfer && owner_q == OWN_FD && sd_data_en;
  assign hd_data_en = xfer && owner_q == OWN_HD && sd_data_en;
  assign sd_data_out = owner_q == OWN_HD ? hd_data_out : owner_q == OWN_FD ? fd_data_out : 8'd0;
  assign owner = owner_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_sd_port_arbiter.sv
// tb_sd_port_arbiter: vector table, directed sequences and randomized transactions
module tb_sd_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] fd_lba = '0;
  logic [1:0] fd_rd = '0, fd_wr = '0;
  logic fd_busy, fd_data_en;
  logic [7:0] fd_data_out = '0;
  logic [31:0] hd_lba = '0;
  logic hd_rd = 1'b0, hd_wr = 1'b0;
  logic hd_busy, hd_data_en;
  logic [7:0] hd_data_out = '0;
  logic [31:0] sd_lba;
  logic [2:0] sd_rd, sd_wr;
  logic sd_busy = 1'b0, sd_data_en = 1'b0;
  logic [7:0] sd_data_out;
  logic [1:0] owner;
  logic timeout_err;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] frd, fwr;
    logic hrd, hwr, sb;
    logic [10:0] flba;
    logic [31:0] hlba;
    logic [2:0] erd, ewr;
    logic [31:0] elba;
    logic [1:0] eown;
    logic efb, ehb;
  } vec_t;
  vec_t tv[12];
  always #5 clk = ~clk;
  sd_port_arbiter #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst),
    .fd_lba(fd_lba), .fd_rd(fd_rd), .fd_wr(fd_wr), .fd_busy(fd_busy),
    .fd_data_en(fd_data_en), .fd_data_out(fd_data_out),
    .hd_lba(hd_lba), .hd_rd(hd_rd), .hd_wr(hd_wr), .hd_busy(hd_busy),
    .hd_data_en(hd_data_en), .hd_data_out(hd_data_out),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_busy(sd_busy),
    .sd_data_en(sd_data_en), .sd_data_out(sd_data_out),
    .owner(owner), .timeout_err(timeout_err)
  );
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic clr;
    fd_rd = '0; fd_wr = '0; hd_rd = 1'b0; hd_wr = 1'b0;
    sd_busy = 1'b0; sd_data_en = 1'b0;
  endtask
  task automatic do_reset;
    clr;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
  endtask
  initial begin
    int nfd, nhd, n, d, len;
    logic fp, hp, last_hd, w_hd, rd_dir;
    logic [1:0] frd, fwr, bits;
    logic hr, hw;
    logic [10:0] flba;
    logic [31:0] hlba, elba;
    logic [2:0] slot;
    tv[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 11'd37,  32'd0,          3'b001, 3'b000, 32'd37,         2'd1, 1'b0, 1'b1};
    tv[1]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'd5,   32'd99,         3'b000, 3'b010, 32'd5,          2'd1, 1'b0, 1'b1};
    tv[2]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 11'd0,   32'hDEADBEEF,   3'b100, 3'b000, 32'hDEADBEEF,   2'd2, 1'b1, 1'b0};
    tv[3]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 11'd0,   32'd7,          3'b100, 3'b000, 32'd7,          2'd2, 1'b1, 1'b0};
    tv[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 11'd12,  32'd0,          3'b001, 3'b000, 32'd12,         2'd1, 1'b0, 1'b1};
    tv[5]  = '{2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 11'h7FF, 32'd0,          3'b010, 3'b000, 32'h7FF,        2'd1, 1'b0, 1'b1};
    tv[6]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 11'd1,   32'd0,          3'b000, 3'b001, 32'd1,          2'd1, 1'b0, 1'b1};
    tv[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 11'd0,   32'hFFFFFFFF,   3'b000, 3'b100, 32'hFFFFFFFF,   2'd2, 1'b1, 1'b0};
    tv[8]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 11'd9,   32'd0,          3'b000, 3'b000, 32'd0,          2'd0, 1'b0, 1'b0};
    tv[9]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'd4,   32'd8,          3'b000, 3'b000, 32'd0,          2'd0, 1'b0, 1'b0};
    tv[10] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 11'd3,   32'd4,          3'b001, 3'b000, 32'd3,          2'd1, 1'b0, 1'b1};
    tv[11] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 11'd2,   32'h0001_2345,  3'b100, 3'b000, 32'h0001_2345,  2'd2, 1'b1, 1'b0};
    clr;
    step;
    chk("reset_fd_busy", fd_busy, 1);
    chk("reset_hd_busy", hd_busy, 1);
    chk("reset_sd_rd", sd_rd, 0);
    chk("reset_sd_wr", sd_wr, 0);
    chk("reset_owner", owner, 0);
    chk("reset_err", timeout_err, 0);
    chk("reset_lba", sd_lba, 0);
    rst = 1'b0;
    step;
    chk("idle_fd_busy", fd_busy, 0);
    chk("idle_hd_busy", hd_busy, 0);
    for (int i = 0; i < 12; i++) begin
      do_reset;
      fd_rd = tv[i].frd; fd_wr = tv[i].fwr; hd_rd = tv[i].hrd; hd_wr = tv[i].hwr;
      fd_lba = tv[i].flba; hd_lba = tv[i].hlba; sd_busy = tv[i].sb;
      step;
      clr;
      #1;
      chk($sformatf("vec%0d_sd_rd", i), sd_rd, tv[i].erd);
      chk($sformatf("vec%0d_sd_wr", i), sd_wr, tv[i].ewr);
      chk($sformatf("vec%0d_lba", i), sd_lba, tv[i].elba);
      chk($sformatf("vec%0d_owner", i), owner, tv[i].eown);
      chk($sformatf("vec%0d_fd_busy", i), fd_busy, tv[i].efb);
      chk($sformatf("vec%0d_hd_busy", i), hd_busy, tv[i].ehb);
    end
    do_reset;
    fd_rd = 2'b01; fd_lba = 11'd37;
    step;
    chk("a_strobe", sd_rd, 3'b001);
    chk("a_lba", sd_lba, 37);
    chk("a_fd_busy_issue", fd_busy, 0);
    step;
    chk("a_strobe_held", sd_rd, 3'b001);
    sd_busy = 1'b1;
    #1;
    chk("a_strobe_clear", sd_rd, 0);
    chk("a_fd_busy_mirror", fd_busy, 1);
    chk("a_hd_busy", hd_busy, 1);
    fd_rd = '0;
    step;
    nfd = 0; nhd = 0;
    for (int c = 0; c < 520; c++) begin
      sd_data_en = c < 512;
      #1;
      nfd += int'(fd_data_en);
      nhd += int'(hd_data_en);
      step;
    end
    chk("a_fd_data_en_count", nfd, 512);
    chk("a_hd_data_en_count", nhd, 0);
    sd_data_en = 1'b0; sd_busy = 1'b0;
    #1;
    chk("a_fd_busy_drop", fd_busy, 0);
    step;
    chk("a_release_fd_busy", fd_busy, 0);
    step;
    chk("a_idle_owner", owner, 0);
    chk("a_idle_hd_busy", hd_busy, 0);
    do_reset;
    fd_wr = 2'b10; hd_rd = 1'b1; fd_lba = 11'd9; hd_lba = 32'd77;
    step;
    chk("b_fd_wr", sd_wr, 3'b010);
    chk("b_hd_busy_issue", hd_busy, 1);
    fd_wr = '0;
    sd_busy = 1'b1;
    #1;
    chk("b_hd_busy_seen", hd_busy, 1);
    step;
    chk("b_hd_busy_xfer", hd_busy, 1);
    sd_busy = 1'b0;
    step;
    step;
    step;
    chk("b_hd_strobe", sd_rd, 3'b100);
    chk("b_hd_lba", sd_lba, 77);
    chk("b_hd_busy_own", hd_busy, 0);
    chk("b_fd_busy_other", fd_busy, 1);
    chk("b_owner", owner, 2);
    sd_busy = 1'b1;
    hd_rd = 1'b0;
    step;
    hd_data_out = 8'hA5; fd_data_out = 8'h3C; sd_data_en = 1'b1;
    #1;
    chk("b_mux_a5", sd_data_out, 8'hA5);
    chk("b_hd_data_en", hd_data_en, 1);
    chk("b_fd_data_en", fd_data_en, 0);
    hd_data_out = 8'h5A;
    #1;
    chk("b_mux_5a", sd_data_out, 8'h5A);
    clr;
    step;
    step;
    do_reset;
    fd_rd = 2'b01; hd_wr = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step;
      chk($sformatf("rr%0d_owner", t), owner, t % 2 == 0 ? 1 : 2);
      chk($sformatf("rr%0d_strobe", t), t % 2 == 0 ? sd_rd : sd_wr, t % 2 == 0 ? 3'b001 : 3'b100);
      sd_busy = 1'b1;
      step;
      sd_busy = 1'b0;
      step;
      step;
    end
    do_reset;
    fd_rd = 2'b10;
    step;
    fd_rd = '0;
    n = 0;
    while (sd_rd != 0 && n < 200) begin
      n++;
      step;
    end
    chk("t_strobe_cycles", n, 100);
    chk("t_err", timeout_err, 1);
    chk("t_release_fd_busy", fd_busy, 0);
    step;
    chk("t_idle_owner", owner, 0);
    hd_rd = 1'b1;
    step;
    chk("t_next_grant", sd_rd, 3'b100);
    chk("t_err_sticky", timeout_err, 1);
    sd_busy = 1'b1;
    hd_rd = 1'b0;
    step;
    rst = 1'b1;
    step;
    chk("r_sd_rd", sd_rd, 0);
    chk("r_sd_wr", sd_wr, 0);
    chk("r_owner", owner, 0);
    chk("r_fd_busy", fd_busy, 1);
    chk("r_hd_busy", hd_busy, 1);
    chk("r_err", timeout_err, 0);
    rst = 1'b0;
    sd_busy = 1'b0;
    step;
    chk("r_fd_busy_after", fd_busy, 0);
    chk("r_hd_busy_after", hd_busy, 0);
    do_reset;
    fp = 1'b0; hp = 1'b0; last_hd = 1'b1;
    frd = '0; fwr = '0; hr = 1'b0; hw = 1'b0; flba = '0; hlba = '0;
    for (int it = 0; it < 40; it++) begin
      if (!fp && $urandom_range(0, 9) < 6) begin
        fp = 1'b1;
        frd = 2'($urandom_range(0, 3));
        fwr = 2'($urandom_range(0, 3));
        if (frd == 0 && fwr == 0) frd = 2'b01;
        flba = 11'($urandom);
      end
      if (!hp && ($urandom_range(0, 9) < 6 || !fp)) begin
        hp = 1'b1;
        hr = 1'($urandom_range(0, 1));
        hw = 1'($urandom_range(0, 1));
        if (!hr && !hw) hw = 1'b1;
        hlba = $urandom;
      end
      fd_rd = fp ? frd : 2'b00; fd_wr = fp ? fwr : 2'b00; fd_lba = flba;
      hd_rd = hp && hr; hd_wr = hp && hw; hd_lba = hlba;
      w_hd = hp && (!fp || !last_hd);
      if (w_hd) begin
        rd_dir = hr;
        slot = 3'b100;
        elba = hlba;
      end else begin
        rd_dir = frd != 0;
        bits = rd_dir ? frd : fwr;
        slot = bits[0] ? 3'b001 : 3'b010;
        elba = {21'd0, flba};
      end
      step;
      chk($sformatf("rnd%0d_sd_rd", it), sd_rd, rd_dir ? slot : 3'b000);
      chk($sformatf("rnd%0d_sd_wr", it), sd_wr, rd_dir ? 3'b000 : slot);
      chk($sformatf("rnd%0d_lba", it), sd_lba, elba);
      chk($sformatf("rnd%0d_owner", it), owner, w_hd ? 2 : 1);
      chk($sformatf("rnd%0d_other_busy", it), w_hd ? fd_busy : hd_busy, 1);
      chk($sformatf("rnd%0d_own_busy", it), w_hd ? hd_busy : fd_busy, 0);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        step;
        chk($sformatf("rnd%0d_hold", it), sd_rd | sd_wr, slot);
      end
      sd_busy = 1'b1;
      #1;
      chk($sformatf("rnd%0d_drop", it), sd_rd | sd_wr, 0);
      chk($sformatf("rnd%0d_own_busy_seen", it), w_hd ? hd_busy : fd_busy, 1);
      if (w_hd) begin
        hp = 1'b0; hd_rd = 1'b0; hd_wr = 1'b0;
      end else begin
        fp = 1'b0; fd_rd = '0; fd_wr = '0;
      end
      step;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        sd_data_en = 1'($urandom_range(0, 1));
        fd_data_out = 8'($urandom);
        hd_data_out = 8'($urandom);
        #1;
        chk($sformatf("rnd%0d_data", it), sd_data_out, w_hd ? hd_data_out : fd_data_out);
        chk($sformatf("rnd%0d_fd_en", it), fd_data_en, !w_hd && sd_data_en);
        chk($sformatf("rnd%0d_hd_en", it), hd_data_en, w_hd && sd_data_en);
        step;
      end
      sd_busy = 1'b0; sd_data_en = 1'b0;
      step;
      step;
      last_hd = w_hd;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
